// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared types for the iterative signed multiply/divide unit
package mul_div_pkg;
  localparam int MULDIV_WIDTH = 64;
  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_DIV, OP_REM} muldiv_op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} muldiv_state_e;
endpackage

// File: rtl/mul_div_seq_sign_abs.sv
// sign_abs: splits a two's-complement value into magnitude and sign flag
module sign_abs #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             neg_o
);
  assign neg_o = val_i[WIDTH-1];
  assign mag_o = neg_o ? -val_i : val_i;
endmodule

// File: rtl/mul_div_seq.sv
// mul_div_seq: radix-2 signed MUL/MULH/DIV/REM, one bit per clock
// Divider datapath present only when MULDIV_DIV_EN is defined.
module mul_div_seq
  import mul_div_pkg::*;
#(
  parameter  int WIDTH = MULDIV_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);
  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  hi_q, lo_q, m_q, hi_d, lo_d;
  logic [WIDTH-1:0]  result_q, fix;
  logic              sa_q, sb_q, zero_q, busy_q, done_q, dz_q;
  logic              zero_start, skip_start;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic              a_neg, b_neg;
  logic [WIDTH:0]    sum;
  logic [2*WIDTH-1:0] prod_s;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]    shl, diff;
  logic [WIDTH-1:0]  q_s, r_s, a_s;
`endif

  sign_abs #(.WIDTH(WIDTH)) u_abs_a (.val_i(a), .mag_o(a_mag), .neg_o(a_neg));
  sign_abs #(.WIDTH(WIDTH)) u_abs_b (.val_i(b), .mag_o(b_mag), .neg_o(b_neg));

  always_comb begin
`ifdef MULDIV_DIV_EN
    zero_start = op[1] & (b == '0);
    skip_start = zero_start;
`else
    zero_start = 1'b0;
    skip_start = op[1];
`endif
    state_d = state_q == S_IDLE ? (start ? (skip_start ? S_FIN : S_RUN) : S_IDLE)
            : state_q == S_RUN  ? (cnt_q == CNT_W'(1) ? S_FIN : S_RUN)
            : S_IDLE;
    sum    = {1'b0, hi_q} + {1'b0, lo_q[0] ? m_q : '0};
    prod_s = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    hi_d   = sum[WIDTH:1];
    lo_d   = {sum[0], lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    // restoring step: the partial remainder never exceeds WIDTH bits, so diff[WIDTH] is the borrow
    shl  = {hi_q, lo_q[WIDTH-1]};
    diff = shl - {1'b0, m_q};
    q_s  = (sa_q ^ sb_q) ? -lo_q : lo_q;
    a_s  = sa_q ? -lo_q : lo_q;
    r_s  = sa_q ? -hi_q : hi_q;
    hi_d = op_q[1] ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : hi_d;
    lo_d = op_q[1] ? {lo_q[WIDTH-2:0], ~diff[WIDTH]} : lo_d;
    fix  = op_q == OP_MUL  ? prod_s[WIDTH-1:0]
         : op_q == OP_MULH ? prod_s[2*WIDTH-1:WIDTH]
         : op_q == OP_DIV  ? (zero_q ? '1 : q_s)
         : (zero_q ? a_s : r_s);
`else
    fix  = op_q == OP_MUL  ? prod_s[WIDTH-1:0]
         : op_q == OP_MULH ? prod_s[2*WIDTH-1:WIDTH]
         : '0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d != S_IDLE;
      done_q  <= state_q == S_FIN;
      if (state_q == S_IDLE && start) begin
        // dividend sits in lo so a zero-divisor REM can rebuild a from it
        op_q   <= muldiv_op_e'(op);
        sa_q   <= a_neg;
        sb_q   <= b_neg;
        hi_q   <= '0;
        lo_q   <= op[1] ? a_mag : b_mag;
        m_q    <= op[1] ? b_mag : a_mag;
        cnt_q  <= CNT_W'(WIDTH);
        zero_q <= zero_start;
        dz_q   <= 1'b0;
      end else if (state_q == S_RUN) begin
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (state_q == S_FIN) begin
        result_q <= fix;
        dz_q     <= zero_q;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dz_q;
endmodule
